operand_seq_ctrl: RTL
=====================

# operand_seq_ctrl

Multi-cycle control FSM for the RV32I datapath. It sequences fetch, decode, execute, memory and writeback, and drives the operand-select mux (`use_imm`), the ALU operation, memory requests, register-file write and PC update. It sits between the instruction register / memory interface and the datapath muxes, and replaces hard-wired single-cycle control so memory can stall.

## Interface
- `DATA_WIDTH`, default from `defs.vh` (32): width of the retired-instruction counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `run`  in  1  enables instruction sequencing; sampled in IDLE and at instruction boundaries.
- `opcode`  in  7  `instr[6:0]` from the IR; sampled in DECODE.
- `branch_taken`  in  1  branch comparison result from the ALU; used in EXEC of BRANCH.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory request; held until `mem_ready`.
- `mem_we`  out  1  store request (valid with `mem_req`).
- `addr_sel`  out  1  memory address source: 0 = PC, 1 = ALU result.
- `ir_we`  out  1  IR load enable.
- `use_imm`  out  1  operand-B mux select: 1 = immediate, 0 = rs2.
- `alu_op`  out  2  ALU operation: 00 = add, 01 = sub, 10 = decode from funct fields.
- `reg_we`  out  1  register-file write enable.
- `wb_sel`  out  2  writeback source: 00 = ALU, 01 = memory data, 10 = PC+4.
- `pc_we`  out  1  PC write enable.
- `pc_src`  out  1  next-PC source: 0 = PC+4, 1 = branch/JAL target.
- `instr_done`  out  1  one-cycle pulse when an instruction retires.
- `halted`  out  1  sticky flag after an illegal opcode.
- `retired`  out  DATA_WIDTH  count of retired instructions.

## Operation
- Supported opcodes: R `0110011`, I-ALU `0010011`, LOAD `0000011`, STORE `0100011`, BRANCH `1100011`, JAL `1101111`, LUI `0110111`. Any other opcode is illegal.
- States are IDLE, FETCH, DECODE, EXEC, MEM, WB and HALT. The state and the latched opcode `op_q` are registered. All outputs are combinational from state, `op_q`, `mem_ready` and `branch_taken`. Any output not listed for a state is 0.
- IDLE: if `run`=1, go to FETCH.
- FETCH: `mem_req`=1 and `addr_sel`=0. On `mem_ready`=1, `ir_we`=1 and go to DECODE; otherwise stay in FETCH.
- DECODE: `op_q` <= `opcode`.
  - Legal opcode: go to EXEC.
  - Illegal opcode: go to HALT.
- EXEC:
  - `use_imm`=1 for I-ALU, LOAD, STORE and LUI; 0 otherwise.
  - `alu_op`: 10 for R and I-ALU; 01 for BRANCH; 00 otherwise.
  - BRANCH: `pc_we`=1, `pc_src`=`branch_taken`, `instr_done`=1. Next state is the boundary state.
  - LOAD and STORE go to MEM. All other opcodes go to WB.
- MEM: `mem_req`=1, `addr_sel`=1, `mem_we`=(op is STORE), `use_imm`=1, `alu_op`=00. The cycle completes only when `mem_ready`=1.
  - LOAD: go to WB.
  - STORE: `pc_we`=1, `pc_src`=0, `instr_done`=1. Next state is the boundary state.
- WB: `reg_we`=1 and `pc_we`=1.
  - `wb_sel`: 01 for LOAD, 10 for JAL, 00 otherwise.
  - `pc_src`: 1 for JAL, 0 otherwise.
  - `instr_done`=1. Next state is the boundary state.
- Boundary state: FETCH if `run`=1, else IDLE.
- HALT: `halted`=1 and all other outputs are 0. HALT is left only by reset; `run` is ignored.
- `retired` increments by 1 on every `instr_done` and wraps from 2^DATA_WIDTH−1 to 0.

## Timing
- Reset (`rst_n`=0 at a rising edge) sets state to IDLE, `op_q` to 0 and `retired` to 0.
  - Every output is 0 in the cycle after reset.
  - Reset wins over any in-flight instruction, including the middle of MEM with `mem_req` high. No PC or register write occurs in that cycle.
- Cycle counts from FETCH entry to retirement, with `mem_ready`=1 on the first request cycle:
  - BRANCH: 3 cycles.
  - R, I-ALU, LUI, JAL, STORE: 4 cycles.
  - LOAD: 5 cycles.
- Each cycle of `mem_ready`=0 in FETCH or MEM adds exactly one cycle. `mem_req` and `addr_sel` stay stable throughout the stall.
- `ir_we` and `pc_we` are asserted at most once per instruction. `instr_done` coincides with the final `pc_we`.
- `run` falling mid-instruction does not abort the instruction. It completes, then the FSM goes to IDLE.
- IDLE to FETCH takes one cycle after `run`=1 is sampled.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `run`=1 and `mem_ready`=1. Required: all outputs 0 and `retired`=0. One cycle after release, the FSM is in FETCH.
- I-ALU (`opcode`=0010011), `mem_ready`=1: FETCH/DECODE/EXEC/WB. `use_imm`=1 and `alu_op`=10 in EXEC; `reg_we`=1 and `wb_sel`=00 in WB; `retired`=1.
- R-type (`opcode`=0110011): `use_imm`=0 in EXEC. Then BRANCH with `branch_taken`=1: retires in 3 cycles with `pc_src`=1; with `branch_taken`=0, `pc_src`=0.
- LOAD with `mem_ready` low for 2 cycles in MEM: 7 cycles total. `mem_req`=1 and `addr_sel`=1 are held throughout MEM; `wb_sel`=01 in WB.
- `opcode`=1111111: HALT entered after DECODE, `halted`=1. With `run` and `mem_ready` toggled for 10 cycles, HALT is held and `retired` does not change. A following reset clears `halted`.
- Reset asserted in MEM of a STORE: no `pc_we`; state is IDLE next cycle. `run`=0 during a STORE: the STORE completes, then the FSM goes to IDLE.

Source files
------------

// File: rtl/operand_seq_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath mux selects, memory requests, RF/PC writes and retirement count.
module operand_seq_ctrl #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic [6:0]            opcode,
  input  logic                  branch_taken,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  addr_sel,
  output logic                  ir_we,
  output logic                  use_imm,
  output logic [1:0]            alu_op,
  output logic                  reg_we,
  output logic [1:0]            wb_sel,
  output logic                  pc_we,
  output logic                  pc_src,
  output logic                  instr_done,
  output logic                  halted,
  output logic [DATA_WIDTH-1:0] retired
);

  localparam int unsigned OP_W = 7;

  localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OP_W-1:0] OP_IALU   = 7'b0010011;
  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  state_e                  state_q, state_d;
  logic [OP_W-1:0]         op_q, op_d;
  logic [DATA_WIDTH-1:0]   retired_q, retired_d;

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    return (op == OP_R) || (op == OP_IALU) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_LUI);
  endfunction

  // Next state and all control outputs; outputs are forced low while reset is held
  // so an in-flight instruction cannot write the PC or register file.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_we      = 1'b0;
    use_imm    = 1'b0;
    alu_op     = ALU_ADD;
    reg_we     = 1'b0;
    wb_sel     = WB_ALU;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    instr_done = 1'b0;
    halted     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        op_d    = opcode;
        state_d = is_legal(opcode) ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        use_imm = (op_q == OP_IALU) || (op_q == OP_LOAD) ||
                  (op_q == OP_STORE) || (op_q == OP_LUI);
        if ((op_q == OP_R) || (op_q == OP_IALU)) alu_op = ALU_FUNCT;
        else if (op_q == OP_BRANCH)              alu_op = ALU_SUB;
        if (op_q == OP_BRANCH) begin
          pc_we      = 1'b1;
          pc_src     = branch_taken;
          instr_done = 1'b1;
          state_d    = run ? S_FETCH : S_IDLE;
        end else if ((op_q == OP_LOAD) || (op_q == OP_STORE)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (op_q == OP_STORE);
        use_imm  = 1'b1;
        if (mem_ready) begin
          if (op_q == OP_STORE) begin
            pc_we      = 1'b1;
            instr_done = 1'b1;
            state_d    = run ? S_FETCH : S_IDLE;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        pc_we      = 1'b1;
        instr_done = 1'b1;
        if (op_q == OP_LOAD)     wb_sel = WB_MEM;
        else if (op_q == OP_JAL) wb_sel = WB_PC4;
        pc_src  = (op_q == OP_JAL);
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (!rst_n) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      addr_sel   = 1'b0;
      ir_we      = 1'b0;
      use_imm    = 1'b0;
      alu_op     = ALU_ADD;
      reg_we     = 1'b0;
      wb_sel     = WB_ALU;
      pc_we      = 1'b0;
      pc_src     = 1'b0;
      instr_done = 1'b0;
      halted     = 1'b0;
    end

    retired_d = instr_done ? retired_q + DATA_WIDTH'(1) : retired_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;

endmodule
